// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, issues reads to the
// instruction memory and hands captured bytes to the decoder over valid/ready.
module instr_fetch #(
   parameter int                 ADDR_W      = 8,
   parameter int                 DATA_W      = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
   parameter int                 MEM_LAT     = 1,
   parameter logic [DATA_W-1:0]  HALT_OPCODE = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_active,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] instr_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      HALTED
   } state_t;

   localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

   state_t            state;
   state_t            next_state;
   logic [2:0]        cnt;
   logic [2:0]        cnt_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              active_nxt;
   logic [DATA_W-1:0] instr_nxt;
   logic              valid_nxt;
   logic              halted_nxt;

   logic fetch_done;
   logic accept;
   logic accept_halt;

   assign fetch_done  = (cnt == CNT_LAST);
   assign accept      = instr_valid && instr_ready;
   assign accept_halt = accept && (instr_out == HALT_OPCODE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         mem_addr    <= '0;
         mem_active  <= 1'b0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= next_state;
         pc          <= pc_nxt;
         mem_addr    <= addr_nxt;
         mem_active  <= active_nxt;
         instr_out   <= instr_nxt;
         instr_valid <= valid_nxt;
         halted      <= halted_nxt;
         cnt         <= cnt_nxt;
      end
   end

   // Branch outranks every other event except reset in all non-halted states.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (!branch_en && start) begin
               next_state = FETCH;
            end
         end
         FETCH: begin
            if (!branch_en && fetch_done) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            if (branch_en) begin
               next_state = FETCH;
            end else if (accept_halt) begin
               next_state = HALTED;
            end else if (accept) begin
               next_state = FETCH;
            end
         end
         HALTED: begin
            next_state = HALTED;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // While fetching, pc tracks mem_addr and only advances at the capture
   // edge, so a redirect simply loads the target into both.
   always_comb begin
      pc_nxt     = pc;
      addr_nxt   = mem_addr;
      active_nxt = mem_active;
      instr_nxt  = instr_out;
      valid_nxt  = instr_valid;
      halted_nxt = halted;
      cnt_nxt    = cnt;
      case (state)
         IDLE: begin
            if (branch_en) begin
               pc_nxt = branch_target;
            end else if (start) begin
               addr_nxt   = pc;
               active_nxt = 1'b1;
               cnt_nxt    = '0;
            end
         end
         FETCH: begin
            if (branch_en) begin
               pc_nxt     = branch_target;
               addr_nxt   = branch_target;
               active_nxt = 1'b1;
               cnt_nxt    = '0;
            end else if (fetch_done) begin
               instr_nxt  = mem_data;
               valid_nxt  = 1'b1;
               active_nxt = 1'b0;
               pc_nxt     = pc + 1'b1;
            end else begin
               cnt_nxt = cnt + 3'd1;
            end
         end
         HOLD: begin
            if (branch_en) begin
               valid_nxt  = 1'b0;
               pc_nxt     = branch_target;
               addr_nxt   = branch_target;
               active_nxt = 1'b1;
               cnt_nxt    = '0;
            end else if (accept_halt) begin
               valid_nxt  = 1'b0;
               halted_nxt = 1'b1;
            end else if (accept) begin
               valid_nxt  = 1'b0;
               addr_nxt   = pc;
               active_nxt = 1'b1;
               cnt_nxt    = '0;
            end
         end
         HALTED: begin
            halted_nxt = 1'b1;
         end
         default: begin
            valid_nxt  = 1'b0;
            active_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage sitting directly upstream of the instruction register/memory.
- Owns the 8-bit program counter and drives the memory's read address and `mem_active` strobe.
- Captures the returned instruction byte and presents it to the decoder over a valid/ready handshake.
- Supports branch redirect and halts on a dedicated opcode.

Parameters:
- ADDR_W, 8, program counter / memory address width.
- DATA_W, 8, instruction width.
- RESET_PC, 8'h00, PC value after reset.
- MEM_LAT, 1, clock edges from asserting `mem_active` to valid `mem_data` (legal range 1..7).
- HALT_OPCODE, 8'hFF, instruction byte that stops fetching.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin fetching from the current PC; only acted on in IDLE.
- mem_addr  output  ADDR_W  read address to the instruction memory, registered.
- mem_active  output  1  memory read enable, registered.
- mem_data  input  DATA_W  instruction byte returned by the memory.
- instr_out  output  DATA_W  captured instruction to the decoder, registered.
- instr_valid  output  1  `instr_out` holds an undelivered instruction.
- instr_ready  input  1  decoder accepts `instr_out`.
- branch_en  input  1  redirect PC, single-cycle pulse.
- branch_target  input  ADDR_W  redirect address.
- pc  output  ADDR_W  current program counter.
- halted  output  1  fetch stopped by HALT_OPCODE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - mem_addr=0, mem_active=0.
  - instr_out=0, instr_valid=0, halted=0, latency counter=0.
- Reset has immediate effect in any state and mid-fetch; any in-flight fetch is discarded.
- States: IDLE, FETCH, HOLD, HALTED.
- IDLE:
  - start=1 at an edge -> FETCH; mem_addr<=pc, mem_active<=1, cnt<=0.
  - start=0 -> stay in IDLE.
- FETCH:
  - mem_active stays 1 and mem_addr stays stable; cnt increments each edge.
  - At the edge where cnt==MEM_LAT-1: instr_out<=mem_data, instr_valid<=1, mem_active<=0, pc<=pc+1 -> HOLD.
  - Net effect: instr_valid rises MEM_LAT edges after the edge that raised mem_active.
- HOLD:
  - instr_out and instr_valid stay stable until the handshake.
  - Handshake = instr_valid && instr_ready at an edge. On it, instr_valid<=0, then:
    - If instr_out==HALT_OPCODE -> HALTED; halted<=1, mem_active stays 0.
    - Otherwise -> FETCH in the same edge: mem_addr<=pc (already incremented), mem_active<=1, cnt<=0.
  - Throughput is one instruction per MEM_LAT+1 cycles with instr_ready held high.
- HALTED: absorbing; start and branch_en are ignored; only reset exits.
- PC arithmetic: pc+1 is modulo 2^ADDR_W, so 8'hFF wraps to 8'h00 with no flag.
- Branch (branch_en=1 at an edge, priority over everything except reset):
  - IDLE: pc<=branch_target; stay IDLE.
  - FETCH: abort the current read, do not capture mem_data. pc<=branch_target+1, mem_addr<=branch_target, mem_active stays 1, cnt<=0; restart FETCH. The target is fetched and the PC advances as normal; the implementation may equivalently hold pc=target until capture.
    - Required observable: next instr_valid delivers mem[branch_target] and pc afterwards is branch_target+1.
  - HOLD: the held instruction is dropped even if instr_ready=1 on the same edge. instr_valid<=0, mem_addr<=branch_target, mem_active<=1 -> FETCH. A HALT_OPCODE held in HOLD is also dropped (no halt).
- start while not in IDLE: ignored.
- instr_ready while instr_valid=0: ignored.
- mem_data is sampled only at the capture edge; its value at other times is don't-care.

Test Plan:
- Reset mid-FETCH: rst_n low asynchronously with mem_active=1 -> mem_active, instr_valid, mem_addr go to 0 immediately; pc=RESET_PC.
- Basic fetch: memory mem[0]=8'h02, mem[1]=8'h06, mem[2]=8'hFF; pulse start; instr_ready=1.
  - instr_out sequence is 02, 06, FF, with instr_valid rising 1 edge after each mem_active rise.
  - After FF is accepted, halted=1, mem_active stays 0, pc=3.
- Backpressure: instr_ready=0 for 5 cycles after the first capture -> instr_out=02 stays stable, instr_valid stays 1, mem_active=0, pc=1; raising instr_ready resumes with mem_addr=1.
- Branch in HOLD: branch_en with branch_target=8'h10 while instr_valid=1 and instr_ready=1 -> instruction dropped; next delivered is mem[16]; pc then reads 8'h11.
- Wrap: RESET_PC=8'hFF, mem[255]=8'h01, mem[0]=8'h03 -> delivers 01 then 03; pc goes FF->00->01.
- Latency: MEM_LAT=3 -> instr_valid rises exactly 3 edges after mem_active rises; the memory model returns garbage before that edge and it must not be captured.
